// File: rtl/flag_packer_pkg.sv
// flag_packer_pkg: shared types and helpers for the flag packer.
// Optional feature macro used by this slice: FLAG_PACKER_DUP_CHK_EN.
package flag_packer_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_LEN       = 32;
  localparam int DEF_CNT_WIDTH = $clog2(DEF_LEN + 1);

  // Width needed to hold a count from 0 to len inclusive.
  function automatic int f_cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

  // One-hot of addr over DEF_LEN bits; zero when addr is out of range.
  function automatic logic [DEF_LEN-1:0] f_onehot(input int addr);
    logic [DEF_LEN-1:0] v;
    v = '0;
    for (int i = 0; i < DEF_LEN; i++) v[i] = (addr == i);
    return v;
  endfunction

endpackage

// File: rtl/flag_packer_onehot_dec.sv
// onehot_dec: combinational address-to-one-hot decoder, the inverse of the
// first-one encoder. Addresses >= LEN decode to all zeros.
module onehot_dec
  import flag_packer_pkg::*;
#(
  parameter int LEN        = DEF_LEN,
  parameter int ADDR_WIDTH = $clog2(LEN)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [LEN-1:0]        oh
);

  // One comparator per flag bit; out-of-range addresses match none of them.
  for (genvar i = 0; i < LEN; i++) begin : g_bit
    assign oh[i] = (int'(addr) == i);
  end

endmodule

// File: rtl/flag_packer.sv
// flag_packer: rebuilds a LEN-bit flag array plus popcount from a stream of
// set-bit addresses framed by in_last, one packed frame per in_last.
// Optional feature: FLAG_PACKER_DUP_CHK_EN adds out_dup, a per-frame sticky
// flag for repeated or out-of-range addresses.
module flag_packer
  import flag_packer_pkg::*;
#(
  parameter int LEN        = DEF_LEN,
  parameter int ADDR_WIDTH = $clog2(LEN),
  parameter int CNT_WIDTH  = f_cnt_width(LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_last,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [LEN-1:0]        out_flag,
`ifdef FLAG_PACKER_DUP_CHK_EN
  output logic                  out_dup,
`endif
  output logic [CNT_WIDTH-1:0]  out_cnt
);

  state_t               state;
  logic [LEN-1:0]       acc, oh, acc_nxt;
  logic [CNT_WIDTH-1:0] acc_cnt, cnt_nxt;
  logic                 beat, take, slot_free;

  onehot_dec #(.LEN(LEN), .ADDR_WIDTH(ADDR_WIDTH)) u_dec (
    .addr (in_addr),
    .oh   (oh)
  );

  // HOLD means a finished frame is parked in acc, so no new beats.
  assign in_rdy    = (state == ACC) && !rst;
  assign beat      = in_vld && in_rdy;
  assign take      = out_vld && out_rdy;
  assign slot_free = !out_vld || out_rdy;
  assign acc_nxt   = acc | oh;
  // Count only bits that were not already set in this frame.
  assign cnt_nxt   = acc_cnt + CNT_WIDTH'(|(oh & ~acc));

`ifdef FLAG_PACKER_DUP_CHK_EN
  logic dup_acc, dup_beat;
  assign dup_beat = (int'(in_addr) >= LEN) || (|(oh & acc));
`endif

  // Accumulate beats, publish on last, park one frame in acc under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACC;
      acc      <= '0;
      acc_cnt  <= '0;
      out_vld  <= 1'b0;
      out_flag <= '0;
      out_cnt  <= '0;
`ifdef FLAG_PACKER_DUP_CHK_EN
      dup_acc  <= 1'b0;
      out_dup  <= 1'b0;
`endif
    end else begin
      // Drained with nothing loaded this cycle; any load below overrides.
      if (take) out_vld <= 1'b0;
      case (state)
        ACC: begin
          if (beat) begin
            if (in_last && slot_free) begin
              out_flag <= acc_nxt;
              out_cnt  <= cnt_nxt;
              out_vld  <= 1'b1;
              acc      <= '0;
              acc_cnt  <= '0;
`ifdef FLAG_PACKER_DUP_CHK_EN
              out_dup  <= dup_acc | dup_beat;
              dup_acc  <= 1'b0;
`endif
            end else begin
              acc     <= acc_nxt;
              acc_cnt <= cnt_nxt;
`ifdef FLAG_PACKER_DUP_CHK_EN
              dup_acc <= dup_acc | dup_beat;
`endif
              if (in_last) state <= HOLD;
            end
          end
        end
        HOLD: begin
          // Swap the parked frame in on the handshake: no bubble on out_vld.
          if (take) begin
            out_flag <= acc;
            out_cnt  <= acc_cnt;
            out_vld  <= 1'b1;
            acc      <= '0;
            acc_cnt  <= '0;
`ifdef FLAG_PACKER_DUP_CHK_EN
            out_dup  <= dup_acc;
            dup_acc  <= 1'b0;
`endif
            state    <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_flag_packer.sv
// tb_flag_packer: two packers (LEN=32 and LEN=20) share one input stream and
// are checked every cycle against a frame-queue model, plus literal checks.
// FLAG_PACKER_DUP_CHK_EN, when defined, also enables the out_dup checks.
module tb_flag_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld = 1'b0;
  logic [4:0]  in_addr = '0;
  logic        in_last = 1'b0;
  logic        out_rdy = 1'b0;

  logic        a_in_rdy, a_out_vld, a_dup;
  logic [31:0] a_flag;
  logic [5:0]  a_cnt;
  logic        b_in_rdy, b_out_vld, b_dup;
  logic [19:0] b_flag;
  logic [4:0]  b_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  flag_packer #(.LEN(32)) dut_a (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(a_in_rdy),
    .in_addr(in_addr), .in_last(in_last), .out_vld(a_out_vld),
    .out_rdy(out_rdy), .out_flag(a_flag),
`ifdef FLAG_PACKER_DUP_CHK_EN
    .out_dup(a_dup),
`endif
    .out_cnt(a_cnt)
  );

  flag_packer #(.LEN(20)) dut_b (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(b_in_rdy),
    .in_addr(in_addr), .in_last(in_last), .out_vld(b_out_vld),
    .out_rdy(out_rdy), .out_flag(b_flag),
`ifdef FLAG_PACKER_DUP_CHK_EN
    .out_dup(b_dup),
`endif
    .out_cnt(b_cnt)
  );

`ifndef FLAG_PACKER_DUP_CHK_EN
  assign a_dup = 1'b0;
  assign b_dup = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: frames are sets; completed frames wait in a queue of depth <= 2
  // (one presented on the output, at most one parked behind it).
  typedef struct {
    logic [31:0] f32;
    logic [19:0] f20;
    bit          d32;
    bit          d20;
  } frm_t;

  frm_t        q[$];
  logic [31:0] m_acc32 = '0;
  logic [19:0] m_acc20 = '0;
  bit          m_dup32 = 1'b0;
  bit          m_dup20 = 1'b0;

  always @(posedge clk) begin
    bit   acc_ok, take;
    int   a;
    frm_t f;
    started <= 1'b1;
    if (rst) begin
      q.delete();
      m_acc32 = '0; m_acc20 = '0; m_dup32 = 1'b0; m_dup20 = 1'b0;
    end else begin
      acc_ok = in_vld && (q.size() < 2);
      take   = (q.size() > 0) && out_rdy;
      if (take) void'(q.pop_front());
      if (acc_ok) begin
        a = int'(in_addr);
        if (m_acc32[a]) m_dup32 = 1'b1;
        m_acc32[a] = 1'b1;
        if (a < 20) begin
          if (m_acc20[a]) m_dup20 = 1'b1;
          m_acc20[a] = 1'b1;
        end else begin
          m_dup20 = 1'b1;
        end
        if (in_last) begin
          f.f32 = m_acc32; f.f20 = m_acc20; f.d32 = m_dup32; f.d20 = m_dup20;
          q.push_back(f);
          m_acc32 = '0; m_acc20 = '0; m_dup32 = 1'b0; m_dup20 = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("in_rdy_a", 64'(a_in_rdy), 64'(!rst && q.size() < 2));
      chk("in_rdy_b", 64'(b_in_rdy), 64'(!rst && q.size() < 2));
      chk("out_vld_a", 64'(a_out_vld), 64'(q.size() > 0));
      chk("out_vld_b", 64'(b_out_vld), 64'(q.size() > 0));
      if (q.size() > 0 && a_out_vld && b_out_vld) begin
        chk("flag_a", 64'(a_flag), 64'(q[0].f32));
        chk("cnt_a", 64'(a_cnt), 64'($countones(q[0].f32)));
        chk("flag_b", 64'(b_flag), 64'(q[0].f20));
        chk("cnt_b", 64'(b_cnt), 64'($countones(q[0].f20)));
`ifdef FLAG_PACKER_DUP_CHK_EN
        chk("dup_a", 64'(a_dup), 64'(q[0].d32));
        chk("dup_b", 64'(b_dup), 64'(q[0].d20));
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input int a, input bit last);
    int n;
    n = 0;
    in_vld = 1'b1; in_addr = a[4:0]; in_last = last;
    @(negedge clk);
    while (!a_in_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_in_rdy) begin
      n_chk++; n_fail++;
      $display("FAIL beat_timeout: in_rdy got 0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    in_vld = 1'b0; out_rdy = 1'b1;
    tick(4);
  endtask

  initial begin
    int k;
    // Reset state
    tick(2);
    chk("rst_in_rdy", 64'(a_in_rdy), 64'h0);
    chk("rst_out_vld", 64'(a_out_vld), 64'h0);
    chk("rst_flag", 64'(a_flag), 64'h0);
    chk("rst_cnt", 64'(a_cnt), 64'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_rdy", 64'(a_in_rdy), 64'h1);

    // Single frame
    out_rdy = 1'b1;
    send_beat(3, 1'b0); send_beat(0, 1'b0); send_beat(31, 1'b1);
    chk("t1_vld", 64'(a_out_vld), 64'h1);
    chk("t1_flag", 64'(a_flag), 64'h8000_0009);
    chk("t1_cnt", 64'(a_cnt), 64'd3);
    drain();

    // Duplicates
    send_beat(5, 1'b0); send_beat(5, 1'b0); send_beat(5, 1'b1);
    chk("t2_flag", 64'(a_flag), 64'h20);
    chk("t2_cnt", 64'(a_cnt), 64'd1);
`ifdef FLAG_PACKER_DUP_CHK_EN
    chk("t2_dup", 64'(a_dup), 64'h1);
`endif
    drain();

    // Stall: A published, B parked, then one-cycle release swaps in B
    out_rdy = 1'b0;
    send_beat(1, 1'b1);
    send_beat(2, 1'b1);
    chk("t3_in_rdy_low", 64'(a_in_rdy), 64'h0);
    chk("t3_flag_a", 64'(a_flag), 64'h2);
    tick(2);
    chk("t3_flag_a_held", 64'(a_flag), 64'h2);
    out_rdy = 1'b1;
    tick(1);
    out_rdy = 1'b0;
    chk("t3_flag_b", 64'(a_flag), 64'h4);
    chk("t3_vld_b", 64'(a_out_vld), 64'h1);
    chk("t3_in_rdy_back", 64'(a_in_rdy), 64'h1);
    drain();

    // Streaming single-beat frames
    for (k = 0; k < 8; k++) begin
      send_beat(k, 1'b1);
      chk("t4_vld", 64'(a_out_vld), 64'h1);
      chk("t4_flag", 64'(a_flag), 64'h1 << k);
      chk("t4_cnt", 64'(a_cnt), 64'd1);
    end
    drain();

    // Reset mid-frame discards the partial frame
    send_beat(4, 1'b0); send_beat(9, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    send_beat(0, 1'b1);
    chk("t5_flag", 64'(a_flag), 64'h1);
    chk("t5_cnt", 64'(a_cnt), 64'd1);
    drain();

    // Out-of-range on the LEN=20 instance
    send_beat(25, 1'b1);
    chk("t6_vld_b", 64'(b_out_vld), 64'h1);
    chk("t6_flag_b", 64'(b_flag), 64'h0);
    chk("t6_cnt_b", 64'(b_cnt), 64'h0);
    chk("t6_flag_a", 64'(a_flag), 64'h0200_0000);
`ifdef FLAG_PACKER_DUP_CHK_EN
    chk("t6_dup_b", 64'(b_dup), 64'h1);
`endif
    drain();

    // Randomized traffic, with small address pools to force duplicates
    for (int c = 0; c < 3000; c++) begin
      in_vld  = ($urandom_range(3) != 0);
      in_addr = ($urandom_range(2) == 0) ? 5'($urandom_range(3)) : 5'($urandom_range(31));
      in_last = ($urandom_range(3) == 0);
      out_rdy = ($urandom_range(2) != 0);
      rst     = ($urandom_range(499) == 0);
      tick(1);
    end
    rst = 1'b0; in_last = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
